u_lsu: RTL and testbench
========================

// Module: u_lsu
// PURPOSE
// - Load/store stage directly downstream of the execute stage. Takes the execute-stage ALU result as the effective address.
// - Runs a req/gnt/rvalid transaction on the data-memory port and formats load data.
// - Writes load results to the regfile write port and raises misalign/illegal/timeout exceptions.
// - Stalls the pipeline through in_rdy while a transaction is in flight.
// PARAMETERS
// - MAX_WAIT  15  max cycles in WAIT for dm_rvalid before timeout (1..255)
// PORTS
// - clk        in   1   clock, all state on posedge
// - rst        in   1   asynchronous active-high reset
// - flush      in   1   hazard flush; blocks acceptance this cycle
// - ld_v       in   1   load request from execute
// - st_v       in   1   store request from execute
// - funct3     in   3   access size/sign (RV32I encoding)
// - rd_a       in   5   load destination register
// - adr        in   32  effective address (alu_o)
// - st_d       in   32  store data (rs2 value)
// - in_rdy     out  1   1 = can accept; 0 = stall upstream
// - dm_req     out  1   memory request, held until dm_gnt
// - dm_we      out  1   1 = write
// - dm_be      out  4   byte enables
// - dm_adr     out  32  word address, {adr[31:2],2'b00}
// - dm_wd      out  32  lane-replicated write data
// - dm_gnt     in   1   request accepted
// - dm_rvalid  in   1   read data valid
// - dm_rd      in   32  read data word
// - rf_rd_e    out  1   regfile write enable, 1-cycle pulse
// - rf_rd_a    out  5   regfile write address
// - rf_rd_i    out  32  regfile write data
// - exc_v      out  1   exception pulse, 1 cycle
// - exc_code   out  2   0 misaligned ld, 1 misaligned st, 2 illegal funct3, 3 load timeout
// - exc_adr    out  32  faulting effective address
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 except in_rdy=1; timeout counter 0.
// - Reset is async. Asserting it mid-transaction abandons the transaction; no rf write or exc.
// - in_rdy = (state==IDLE).
// - Accept = in_rdy & (ld_v|st_v) & !flush. On accept, latch funct3, rd_a, adr, st_d.
// - ld_v & st_v together is a protocol violation and is asserted against in the bench.
// - Legal funct3: ld 000/001/010/100/101; st 000/001/010. Any other value -> exc code 2.
// - Misaligned: half with adr[0]=1, word with adr[1:0]!=0.
// - Accept with illegal or misaligned access: no dm_req. exc_v pulses the next cycle with exc_adr=adr. State stays IDLE.
// - FSM:
//   - IDLE -> REQ on a good accept.
//   - REQ: dm_req=1 and addr/be/wd stable until dm_gnt. On gnt: store -> IDLE, load -> WAIT.
//   - WAIT: dm_req=0, counter increments each cycle.
//     - dm_rvalid -> capture and format, rf_rd_e pulses next cycle, -> IDLE.
//     - Counter reaches MAX_WAIT without dm_rvalid -> exc code 3, -> IDLE.
// - dm_rvalid is only legal in WAIT. It is ignored in other states.
// - Load latency with gnt in the first REQ cycle and rvalid in the first WAIT cycle:
//   - accept cycle T; REQ at T+1; WAIT at T+2; rf_rd_e at T+3.
// - Store completes at gnt. Next accept is possible in the cycle after gnt.
// - Byte enables: SB 4'b0001<<adr[1:0]; SH 4'b0011<<adr[1:0]; SW 4'b1111.
// - Write data: SB {4{st_d[7:0]}}; SH {2{st_d[15:0]}}; SW st_d.
// - Load format: lane = dm_rd >> (8*adr[1:0]).
//   - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
// - rd_a=0: the memory access still happens, but rf_rd_e stays 0.
// - flush during REQ/WAIT has no effect; an issued access always completes.
// STRUCTURE
// - lsu_pkg: state enum {IDLE,REQ,WAIT}; funct3 constants F3_B/H/W/BU/HU; exc_code constants; function be_gen(f3,adr[1:0]).
// - Sub-module u_lsu_fmt: combinational load aligner/extender (dm_rd, adr[1:0], funct3 -> 32b).
// TESTING
// - SW adr=0x100 st_d=0xDEADBEEF, gnt at once -> dm_we=1, be=1111, dm_adr=0x100, in_rdy high the cycle after gnt.
// - SB adr=0x103 st_d=0x000000A5 -> be=1000, dm_wd=0xA5A5A5A5.
// - LB adr=0x202, dm_rd=0x12807F34, rd_a=5 -> rf_rd_a=5, rf_rd_i=0xFFFFFF80.
//   - Same access as LBU -> rf_rd_i=0x00000080. rf_rd_e exactly 1 cycle, at T+3.
// - LH adr=0x201 -> no dm_req; exc_v=1, exc_code=0, exc_adr=0x201.
//   - funct3=3'b011 load -> exc_code=2.
// - LW with gnt delayed 3 cycles, then no rvalid for MAX_WAIT cycles:
//   - dm_req held stable all 3 cycles; then exc_code=3, state IDLE, rf_rd_e=0.
// - flush=1 with ld_v=1 -> no accept. rst asserted in WAIT -> all outputs 0, in_rdy=1, later rvalid ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Purpose: shared types and helpers for the load/store unit.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: FSM state enum, funct3 size/sign codes, exception codes, be_gen().
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EXC_MIS_LD = 2'd0;
  localparam logic [1:0] EXC_MIS_ST = 2'd1;
  localparam logic [1:0] EXC_ILL    = 2'd2;
  localparam logic [1:0] EXC_TMO    = 2'd3;

  // Byte enables for an access; funct3[1:0] carries the size.
  // Only called for aligned accesses, so the shift never spills out.
  function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   be_gen = 4'b0001 << a;
      2'b01:   be_gen = 4'b0011 << a;
      default: be_gen = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Purpose: data-memory req/gnt/rvalid port bundle.
// Latency: n/a (wires only).
// Backpressure: req is held by the master until gnt; rvalid/rd are unconditional.
// Ports: req, we, be, adr, wd (master -> memory); gnt, rvalid, rd (memory -> master).
interface lsu_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] adr;
  logic [31:0] wd;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rd;

  modport master (output req, we, be, adr, wd, input gnt, rvalid, rd);
  modport slave  (input req, we, be, adr, wd, output gnt, rvalid, rd);
endinterface

// File: rtl/u_lsu_fmt.sv
// Purpose: load data aligner and sign/zero extender.
// Latency: combinational.
// Backpressure: none.
// Ports: rd (memory word), lane (adr[1:0]), f3 (funct3) -> res (regfile value).
module u_lsu_fmt
  import lsu_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [1:0]  lane,
  input  logic [2:0]  f3,
  output logic [31:0] res
);

  logic [31:0] sh;

  always_comb begin
    sh  = rd >> {lane, 3'b000};
    res = sh;
    case (f3)
      F3_B:    res = {{24{sh[7]}}, sh[7:0]};
      F3_H:    res = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   res = {24'h000000, sh[7:0]};
      F3_HU:   res = {16'h0000, sh[15:0]};
      default: res = sh;
    endcase
  end

endmodule

// File: rtl/u_lsu.sv
// Purpose: load/store stage; runs one data-memory transaction, writes loads back, raises exceptions.
// Latency: load accept T -> rf write at T+3 best case; store done at gnt; exceptions 1 cycle after cause.
// Backpressure: in_rdy low whenever a transaction is in REQ or WAIT; flush blocks acceptance.
// Ports: execute request (ld_v/st_v/funct3/rd_a/adr/st_d), in_rdy, dm (memory master),
//        regfile write (rf_rd_e/rf_rd_a/rf_rd_i), exception (exc_v/exc_code/exc_adr).
module u_lsu
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ld_v,
  input  logic        st_v,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd_a,
  input  logic [31:0] adr,
  input  logic [31:0] st_d,
  output logic        in_rdy,
  lsu_if.master       dm,
  output logic        rf_rd_e,
  output logic [4:0]  rf_rd_a,
  output logic [31:0] rf_rd_i,
  output logic        exc_v,
  output logic [1:0]  exc_code,
  output logic [31:0] exc_adr
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  lsu_state_e  state, state_nxt;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [31:0] adr_q;
  logic [31:0] st_q;
  logic        is_st_q;
  logic [7:0]  cnt;

  logic        accept, legal, misal, good, bad;
  logic        req, rsp, tmo;
  logic [31:0] wd;
  logic [31:0] fmt_o;

  assign in_rdy = (state == IDLE);
  assign accept = in_rdy & (ld_v | st_v) & ~flush;

  // Unsigned sub-word codes only exist for loads.
  always_comb begin
    legal = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ld_v;
      default:          legal = 1'b0;
    endcase
  end

  assign misal = ((funct3[1:0] == 2'b01) & adr[0]) |
                 ((funct3[1:0] == 2'b10) & (adr[1:0] != 2'b00));
  assign good  = accept & legal & ~misal;
  assign bad   = accept & ~(legal & ~misal);

  assign req = (state == REQ);
  assign rsp = (state == WAIT) & dm.rvalid;
  // Timeout fires on the MAX_WAIT-th WAIT cycle that still has no rvalid.
  assign tmo = (state == WAIT) & ~dm.rvalid & (cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (good) state_nxt = REQ;
      REQ:     if (dm.gnt) state_nxt = is_st_q ? IDLE : WAIT;
      WAIT:    if (rsp | tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q    <= 3'b000;
      rd_q    <= 5'd0;
      adr_q   <= 32'h0;
      st_q    <= 32'h0;
      is_st_q <= 1'b0;
    end else if (accept) begin
      f3_q    <= funct3;
      rd_q    <= rd_a;
      adr_q   <= adr;
      st_q    <= st_d;
      is_st_q <= st_v;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt <= 8'd0;
    else if ((state == WAIT) & ~rsp & ~tmo) cnt <= cnt + 8'd1;
    else                             cnt <= 8'd0;
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00:   wd = {4{st_q[7:0]}};
      2'b01:   wd = {2{st_q[15:0]}};
      default: wd = st_q;
    endcase
  end

  // Port fields are zero outside REQ so the memory side never sees stale values.
  assign dm.req = req;
  assign dm.we  = req & is_st_q;
  assign dm.be  = req ? be_gen(f3_q, adr_q[1:0]) : 4'b0000;
  assign dm.adr = req ? {adr_q[31:2], 2'b00} : 32'h0;
  assign dm.wd  = req ? wd : 32'h0;

  u_lsu_fmt u_fmt (
    .rd   (dm.rd),
    .lane (adr_q[1:0]),
    .f3   (f3_q),
    .res  (fmt_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_rd_e <= 1'b0;
      rf_rd_a <= 5'd0;
      rf_rd_i <= 32'h0;
    end else begin
      // x0 is hard-wired: the access runs but nothing is written back.
      rf_rd_e <= rsp & (rd_q != 5'd0);
      if (rsp) begin
        rf_rd_a <= rd_q;
        rf_rd_i <= fmt_o;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_v    <= 1'b0;
      exc_code <= 2'd0;
      exc_adr  <= 32'h0;
    end else begin
      exc_v <= bad | tmo;
      if (bad) begin
        exc_code <= ~legal ? EXC_ILL : (st_v ? EXC_MIS_ST : EXC_MIS_LD);
        exc_adr  <= adr;
      end else if (tmo) begin
        exc_code <= EXC_TMO;
        exc_adr  <= adr_q;
      end
    end
  end

endmodule

// File: tb/tb_u_lsu.sv
// Purpose: directed self-checking bench for u_lsu with a behavioural expectation model.
// Latency: expected rf/exc events carry the cycle they must appear in.
// Backpressure: the stimulus acts as the memory and tracks when the stage must be busy.
module tb_u_lsu;
  import lsu_pkg::*;

  localparam int MW = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, ld_v, st_v;
  logic [2:0]  funct3;
  logic [4:0]  rd_a;
  logic [31:0] adr, st_d;
  logic        in_rdy, rf_rd_e, exc_v;
  logic [4:0]  rf_rd_a;
  logic [31:0] rf_rd_i, exc_adr;
  logic [1:0]  exc_code;

  lsu_if dm ();

  u_lsu #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ld_v(ld_v), .st_v(st_v),
    .funct3(funct3), .rd_a(rd_a), .adr(adr), .st_d(st_d), .in_rdy(in_rdy),
    .dm(dm), .rf_rd_e(rf_rd_e), .rf_rd_a(rf_rd_a), .rf_rd_i(rf_rd_i),
    .exc_v(exc_v), .exc_code(exc_code), .exc_adr(exc_adr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t rf_q[$];
  ev_t exc_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;

  bit          chk_en = 1'b0;
  bit          busy = 1'b0;
  bit          req_window = 1'b0;
  logic        exp_we;
  logic [3:0]  exp_be;
  logic [31:0] exp_adr, exp_wd;

  logic        obs_we;
  logic [3:0]  obs_be;
  logic [31:0] obs_adr, obs_wd, obs_rf_i, obs_exc_adr;
  logic [4:0]  obs_rf_a;
  logic [1:0]  obs_exc_code;
  int          obs_rf_cyc = -1;
  int          obs_exc_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_size(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit m_legal(input bit is_ld, input logic [2:0] f);
    if (is_ld) return (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
    return (f == 3'd0 || f == 3'd1 || f == 3'd2);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
    logic [3:0] be;
    int off = int'(a % 4);
    int sz = m_size(f);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
    return be;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f, input logic [31:0] d);
    logic [31:0] w;
    int sz = m_size(f);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [2:0] f);
    logic [31:0] v = rd >> (8 * (a % 4));
    bit sgn = (f[2] == 1'b0);
    if (m_size(f) == 1) begin
      v = v & 32'h0000_00FF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (m_size(f) == 2) begin
      v = v & 32'h0000_FFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_rdy", {31'b0, in_rdy}, {31'b0, !busy});
      chk("dm_req", {31'b0, dm.req}, {31'b0, req_window});
      if (dm.req === 1'b1) begin
        chk("dm_we", {31'b0, dm.we}, {31'b0, exp_we});
        chk("dm_be", {28'b0, dm.be}, {28'b0, exp_be});
        chk("dm_adr", dm.adr, exp_adr);
        if (exp_we) chk("dm_wd", dm.wd, exp_wd);
        obs_we  = dm.we;
        obs_be  = dm.be;
        obs_adr = dm.adr;
        obs_wd  = dm.wd;
      end
    end
    if (rf_q.size() > 0 && rf_q[0].due == cyc) begin
      chk("rf_rd_e", {31'b0, rf_rd_e}, 32'd1);
      chk("rf_rd_a", {27'b0, rf_rd_a}, rf_q[0].a);
      chk("rf_rd_i", rf_rd_i, rf_q[0].d);
      obs_rf_a   = rf_rd_a;
      obs_rf_i   = rf_rd_i;
      obs_rf_cyc = cyc;
      void'(rf_q.pop_front());
    end else if (rf_rd_e === 1'b1) begin
      chk("rf_rd_e_unexpected", {31'b0, rf_rd_e}, 32'd0);
    end
    if (exc_q.size() > 0 && exc_q[0].due == cyc) begin
      chk("exc_v", {31'b0, exc_v}, 32'd1);
      chk("exc_code", {30'b0, exc_code}, exc_q[0].a);
      chk("exc_adr", exc_adr, exc_q[0].d);
      obs_exc_code = exc_code;
      obs_exc_adr  = exc_adr;
      obs_exc_cyc  = cyc;
      void'(exc_q.pop_front());
    end else if (exc_v === 1'b1) begin
      chk("exc_v_unexpected", {31'b0, exc_v}, 32'd0);
    end
  end

  always @(negedge clk)
    if (rst === 1'b0) assert (!(ld_v && st_v)) else $error("protocol: ld_v and st_v together");

  // ---------------- stimulus / memory ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit is_ld, input logic [2:0] f, input logic [4:0] rd,
                    input logic [31:0] a, input logic [31:0] d,
                    input int gdly, input int rdly, input logic [31:0] rdata);
    int n = 0;
    ev_t e;
    while (in_rdy !== 1'b1 && n < 50) begin step(); n++; end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL rdy_bound: in_rdy stayed low for %0d cycles", n);
    end
    ld_v = is_ld; st_v = !is_ld; funct3 = f; rd_a = rd; adr = a; st_d = d;
    last_acc = cyc;
    if (!m_legal(is_ld, f) || (a % m_size(f)) != 0) begin
      e.due = cyc + 1;
      e.a   = !m_legal(is_ld, f) ? 32'd2 : (is_ld ? 32'd0 : 32'd1);
      e.d   = a;
      exc_q.push_back(e);
      step();
      ld_v = 1'b0; st_v = 1'b0;
    end else begin
      exp_we  = !is_ld;
      exp_be  = m_be(f, a);
      exp_adr = a & 32'hFFFF_FFFC;
      exp_wd  = m_wd(f, d);
      step();
      ld_v = 1'b0; st_v = 1'b0;
      busy = 1'b1; req_window = 1'b1;
      repeat (gdly) step();
      dm.gnt = 1'b1;
      step();
      dm.gnt = 1'b0; req_window = 1'b0;
      if (!is_ld) begin
        busy = 1'b0;
      end else if (rdly < MW) begin
        repeat (rdly) step();
        dm.rvalid = 1'b1; dm.rd = rdata;
        if (rd != 5'd0) begin
          e.due = cyc + 1; e.a = {27'b0, rd}; e.d = m_load(rdata, a, f);
          rf_q.push_back(e);
        end
        step();
        dm.rvalid = 1'b0; busy = 1'b0;
      end else begin
        repeat (MW) step();
        busy = 1'b0;
        e.due = cyc; e.a = 32'd3; e.d = a;
        exc_q.push_back(e);
      end
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ld_v = 1'b0; st_v = 1'b0; funct3 = 3'b000;
    rd_a = 5'd0; adr = 32'h0; st_d = 32'h0;
    dm.gnt = 1'b0; dm.rvalid = 1'b0; dm.rd = 32'h0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_in_rdy", {31'b0, in_rdy}, 32'd1);
    chk("rst_dm_req", {31'b0, dm.req}, 32'd0);
    chk("rst_rf_rd_e", {31'b0, rf_rd_e}, 32'd0);
    chk("rst_exc_v", {31'b0, exc_v}, 32'd0);
    chk("rst_dm_adr", dm.adr, 32'h0);
    rst = 1'b0;
    step();
    chk_en = 1'b1;

    // SW with immediate grant; stage is ready again right after gnt
    op(0, F3_W, 5'd0, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0);
    chk("sw_we", {31'b0, obs_we}, 32'd1);
    chk("sw_be", {28'b0, obs_be}, 32'h0000_000F);
    chk("sw_adr", obs_adr, 32'h0000_0100);
    chk("sw_wd", obs_wd, 32'hDEAD_BEEF);
    chk("sw_rdy_after", {31'b0, in_rdy}, 32'd1);

    op(0, F3_B, 5'd0, 32'h103, 32'h0000_00A5, 0, 0, 32'h0);
    chk("sb_be", {28'b0, obs_be}, 32'h0000_0008);
    chk("sb_wd", obs_wd, 32'hA5A5_A5A5);

    op(0, F3_H, 5'd0, 32'h102, 32'h1234_BEEF, 1, 0, 32'h0);
    chk("sh_be", {28'b0, obs_be}, 32'h0000_000C);
    chk("sh_wd", obs_wd, 32'hBEEF_BEEF);

    op(1, F3_B, 5'd5, 32'h202, 32'h0, 0, 0, 32'h1280_7F34);
    chk("lb_data", obs_rf_i, 32'hFFFF_FF80);
    chk("lb_rd", {27'b0, obs_rf_a}, 32'd5);
    chk("lb_latency", 32'(obs_rf_cyc - last_acc), 32'd3);

    op(1, F3_BU, 5'd5, 32'h202, 32'h0, 0, 0, 32'h1280_7F34);
    chk("lbu_data", obs_rf_i, 32'h0000_0080);
    chk("lbu_latency", 32'(obs_rf_cyc - last_acc), 32'd3);

    op(1, F3_H, 5'd6, 32'h201, 32'h0, 0, 0, 32'h0);
    chk("lh_mis_code", {30'b0, obs_exc_code}, 32'd0);
    chk("lh_mis_adr", obs_exc_adr, 32'h0000_0201);
    chk("lh_mis_cyc", 32'(obs_exc_cyc - last_acc), 32'd1);

    op(1, 3'b011, 5'd6, 32'h200, 32'h0, 0, 0, 32'h0);
    chk("ill_ld_code", {30'b0, obs_exc_code}, 32'd2);

    op(0, F3_W, 5'd0, 32'h102, 32'h1, 0, 0, 32'h0);
    op(0, F3_BU, 5'd0, 32'h100, 32'h1, 0, 0, 32'h0);
    op(1, F3_HU, 5'd9, 32'h206, 32'h0, 2, 2, 32'h8001_7FFF);
    op(1, F3_H, 5'd10, 32'h206, 32'h0, 0, 1, 32'h8001_7FFF);
    op(1, F3_W, 5'd0, 32'h20C, 32'h0, 0, 0, 32'hCAFE_F00D);
    op(1, F3_W, 5'd11, 32'h210, 32'h0, 0, 4, 32'h0BAD_CAFE);

    // grant held off 3 cycles, then no response at all
    op(1, F3_W, 5'd3, 32'h300, 32'h0, 3, MW, 32'h0);
    chk("tmo_code", {30'b0, obs_exc_code}, 32'd3);
    chk("tmo_adr", obs_exc_adr, 32'h0000_0300);
    chk("tmo_cyc", 32'(obs_exc_cyc - last_acc), 32'd20);
    chk("tmo_idle", {31'b0, in_rdy}, 32'd1);

    // flush suppresses acceptance
    flush = 1'b1; ld_v = 1'b1; funct3 = F3_W; adr = 32'h400; rd_a = 5'd4;
    step();
    flush = 1'b0; ld_v = 1'b0;
    step();
    chk("flush_rdy", {31'b0, in_rdy}, 32'd1);
    chk("flush_req", {31'b0, dm.req}, 32'd0);

    // reset while waiting for a response abandons the load
    chk_en = 1'b0;
    ld_v = 1'b1; funct3 = F3_W; adr = 32'h500; rd_a = 5'd7;
    step();
    ld_v = 1'b0;
    dm.gnt = 1'b1;
    step();
    dm.gnt = 1'b0;
    chk("pre_rst_busy", {31'b0, in_rdy}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("wrst_in_rdy", {31'b0, in_rdy}, 32'd1);
    chk("wrst_req", {31'b0, dm.req}, 32'd0);
    chk("wrst_rf_a", {27'b0, rf_rd_a}, 32'd0);
    chk("wrst_rf_i", rf_rd_i, 32'h0);
    chk("wrst_exc_code", {30'b0, exc_code}, 32'd0);
    chk("wrst_exc_adr", exc_adr, 32'h0);
    step();
    rst = 1'b0;
    dm.rvalid = 1'b1; dm.rd = 32'h1111_2222;
    step();
    dm.rvalid = 1'b0;
    repeat (3) step();
    chk("post_rst_rdy", {31'b0, in_rdy}, 32'd1);
    chk_en = 1'b1;
    repeat (2) step();

    chk("rf_q_drained", rf_q.size(), 32'd0);
    chk("exc_q_drained", exc_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
